// File: rtl/ula_serial_if.sv
// ula_serial_if: handshake/bus bundle between the control FSM and the ALU.
//   master : FSM side, drives the request, opcode fields and operands.
//   slave  : ALU side, returns result, flags, ack and busy.
//   ena_ula  - operation request, held until ula_ack is seen
//   mnm_in   - mnemonic (00 pass, 01 logic, 10 ADD, 11 SUB)
//   funct_in - logic function (00 AND, 01 OR, 10 XOR, 11 NOT A)
//   op_a     - operand A (R0)
//   op_b     - operand B (Rd or immediate)
//   result   - registered result
//   flag_z   - registered zero flag
//   flag_c   - registered carry flag (SUB: 1 = no borrow)
//   ula_ack  - registered four-phase acknowledge
//   busy     - high while the ALU is executing
interface ula_serial_if #(
  parameter int WIDTH = 4
);
  logic             ena_ula;
  logic [1:0]       mnm_in;
  logic [1:0]       funct_in;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             ula_ack;
  logic             busy;

  modport master (
    output ena_ula, mnm_in, funct_in, op_a, op_b,
    input  result, flag_z, flag_c, ula_ack, busy
  );

  modport slave (
    input  ena_ula, mnm_in, funct_in, op_a, op_b,
    output result, flag_z, flag_c, ula_ack, busy
  );
endinterface

// File: rtl/ula_serial.sv
// ula_serial: ALU for the 4-bit microcore. Arithmetic (ADD/SUB) runs
// bit-serially LSB first through a single carry flop; pass and logic
// operations finish in one execute cycle. Four-phase handshake with the FSM.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - ula_serial_if.slave (request, operands, result, flags, ack, busy)
module ula_serial #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic         clk,
  input logic         rst,
  ula_serial_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, acc_q;
  logic [1:0]         mnm_q, funct_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   result_q;
  logic               flag_z_q, flag_c_q, ack_q;

  // Serial datapath: operands shift right, so bit 0 is always the current bit.
  logic               sum_bit, carry_out, last_bit;
  logic [WIDTH-1:0]   arith_res, logic_res, done_res;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    logic_res = '0;
    case (funct_q)
      2'b00:   logic_res = a_q & b_q;
      2'b01:   logic_res = a_q | b_q;
      2'b10:   logic_res = a_q ^ b_q;
      default: logic_res = ~a_q;
    endcase
  end

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_out = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  // Sum bits enter at the MSB and migrate down; after WIDTH bits the
  // first (LSB) sum bit has reached position 0.
  assign arith_res = {sum_bit, acc_q[WIDTH-1:1]};
  assign done_res  = mnm_q[1] ? arith_res : (mnm_q[0] ? logic_res : b_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ena_ula) state_d = EXEC;
      // Abort wins over completion: a dropped request never produces an ack.
      EXEC:    if (!bus.ena_ula) state_d = IDLE;
               else if (!mnm_q[1] || last_bit) state_d = DONE;
      DONE:    if (!bus.ena_ula) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mnm_q    <= '0;
      funct_q  <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= (state_d == DONE);
      case (state_q)
        IDLE: if (bus.ena_ula) begin
          a_q     <= bus.op_a;
          // SUB is a + ~b + 1: invert B here and seed the carry with 1.
          b_q     <= (bus.mnm_in == 2'b11) ? ~bus.op_b : bus.op_b;
          mnm_q   <= bus.mnm_in;
          funct_q <= bus.funct_in;
          cnt_q   <= '0;
          carry_q <= (bus.mnm_in == 2'b11);
          acc_q   <= '0;
        end
        EXEC: if (bus.ena_ula) begin
          if (mnm_q[1]) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            acc_q   <= arith_res;
            carry_q <= carry_out;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
          if (!mnm_q[1] || last_bit) begin
            result_q <= done_res;
            flag_c_q <= mnm_q[1] & carry_out;
            flag_z_q <= (done_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.flag_z  = flag_z_q;
  assign bus.flag_c  = flag_c_q;
  assign bus.ula_ack = ack_q;
  assign bus.busy    = (state_q == EXEC);

endmodule

// File: tb/tb_ula_serial.sv
// tb_ula_serial: self-checking bench for ula_serial. Expected results come
// from a behavioural model, are queued when an operation is launched and are
// popped and compared when the DUT acknowledges.
module tb_ula_serial;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ula_serial_if #(.WIDTH(W)) bus ();

  ula_serial #(.WIDTH(W), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_res = '0;
  logic         last_c   = 1'b0;
  logic         last_z   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] mnm, input logic [1:0] funct,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] nb;
    e.c   = 1'b0;
    e.lat = 2;
    e.res = b;
    nb    = ~b;
    case (mnm)
      2'b00: e.res = b;
      2'b01: case (funct)
        2'b00: e.res = a & b;
        2'b01: e.res = a | b;
        2'b10: e.res = a ^ b;
        default: e.res = ~a;
      endcase
      default: begin
        if (mnm == 2'b10) s = {1'b0, a} + {1'b0, b};
        else              s = {1'b0, a} + {1'b0, nb} + 1;
        e.res = s[W-1:0];
        e.c   = s[W];
        e.lat = W + 1;
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Called at a negative edge: drives the request and, if the operation is
  // expected to complete, queues its expected outcome.
  task automatic start_op(input logic [1:0] mnm, input logic [1:0] funct,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit expect_done);
    if (expect_done) sb.push_back(model(mnm, funct, a, b));
    bus.mnm_in   = mnm;
    bus.funct_in = funct;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.ena_ula  = 1'b1;
  endtask

  // Counts edges from the sampling edge until ack, then compares.
  task automatic wait_done(input string tag, input int pre);
    int   edges;
    exp_t e;
    edges = pre;
    while (bus.ula_ack !== 1'b1 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (bus.ula_ack !== 1'b1) check({tag, "_timeout"}, 32'(bus.ula_ack), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(edges), 32'(e.lat));
      check({tag, "_result"}, 32'(bus.result), 32'(e.res));
      check({tag, "_flag_c"}, 32'(bus.flag_c), 32'(e.c));
      check({tag, "_flag_z"}, 32'(bus.flag_z), 32'(e.z));
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      last_res = e.res;
      last_c   = e.c;
      last_z   = e.z;
    end
  endtask

  task automatic release_req(input string tag);
    bus.ena_ula = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack_fall"}, 32'(bus.ula_ack), 32'd0);
  endtask

  typedef struct {
    logic [1:0] mnm;
    logic [1:0] funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  initial begin
    op_t tbl[$];
    tbl.push_back('{2'b10, 2'b00, 4'd7,    4'd9});
    tbl.push_back('{2'b11, 2'b00, 4'd3,    4'd5});
    tbl.push_back('{2'b11, 2'b00, 4'd5,    4'd3});
    tbl.push_back('{2'b01, 2'b10, 4'b1010, 4'b0110});
    tbl.push_back('{2'b01, 2'b11, 4'b1111, 4'b0101});
    tbl.push_back('{2'b01, 2'b00, 4'b1100, 4'b1010});
    tbl.push_back('{2'b01, 2'b01, 4'b1000, 4'b0010});
    tbl.push_back('{2'b00, 2'b00, 4'b0011, 4'b1001});
    tbl.push_back('{2'b10, 2'b00, 4'd15,   4'd15});
    tbl.push_back('{2'b11, 2'b00, 4'd0,    4'd0});

    bus.ena_ula  = 1'b0;
    bus.mnm_in   = '0;
    bus.funct_in = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ack", 32'(bus.ula_ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; the first entry also exercises the held handshake
    foreach (tbl[i]) begin
      start_op(tbl[i].mnm, tbl[i].funct, tbl[i].a, tbl[i].b, 1'b1);
      wait_done($sformatf("op%0d", i), 0);
      if (i == 0) begin
        for (int k = 0; k < 6; k++) begin
          @(posedge clk);
          @(negedge clk);
          check("hold_ack", 32'(bus.ula_ack), 32'd1);
          check("hold_busy", 32'(bus.busy), 32'd0);
        end
        check("hold_result", 32'(bus.result), 32'(last_res));
      end
      release_req($sformatf("op%0d", i));
    end

    // Operand change after sampling must not affect the running ADD
    start_op(2'b10, 2'b00, 4'd1, 4'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.op_a = 4'hF;
    wait_done("opchg", 1);
    release_req("opchg");

    // Abort during EXEC: no ack, result and flags unchanged
    start_op(2'b10, 2'b00, 4'd6, 4'd5, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    bus.ena_ula = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_ack", 32'(bus.ula_ack), 32'd0);
    end
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'(last_res));
    check("abort_flags", {30'd0, bus.flag_c, bus.flag_z}, {30'd0, last_c, last_z});

    // Asynchronous reset mid-EXEC, then a fresh operation with ena held high
    start_op(2'b10, 2'b00, 4'd3, 4'd4, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("mrst_result", 32'(bus.result), 32'd0);
    check("mrst_flags", {30'd0, bus.flag_c, bus.flag_z}, 32'd0);
    check("mrst_ack", 32'(bus.ula_ack), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_op(2'b10, 2'b00, 4'd3, 4'd4, 1'b1);
    wait_done("after_rst", 0);
    release_req("after_rst");

    // Random operations
    for (int i = 0; i < 12; i++) begin
      start_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b1);
      wait_done($sformatf("rnd%0d", i), 0);
      release_req($sformatf("rnd%0d", i));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
